// File: rtl/pcie_fifo_pkg.sv
// Shared definitions for the parametrised PCIe lane FIFO.
// Holds the depth and count-width helpers and the bit positions of the
// status bus that the lane controller assembles from the FIFO flags.
package pcie_fifo_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 6;
  localparam int unsigned DEF_ADDR_WIDTH = 2;
  localparam int unsigned DEPTH          = 1 << DEF_ADDR_WIDTH;
  localparam int unsigned CNT_WIDTH      = DEF_ADDR_WIDTH + 1;

  // Status bus bit indices
  localparam int unsigned FULL         = 0;
  localparam int unsigned EMPTY        = 1;
  localparam int unsigned AFULL        = 2;
  localparam int unsigned AEMPTY       = 3;
  localparam int unsigned OVF          = 4;
  localparam int unsigned UDF          = 5;
  localparam int unsigned STATUS_WIDTH = 6;

  // Number of entries for a given address width
  function automatic int unsigned fifo_depth(input int unsigned addr_width);
    return 1 << addr_width;
  endfunction

  // Occupancy counter width: one extra bit so DEPTH itself is representable
  function automatic int unsigned fifo_cnt_width(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/pcie_fifo_flags.sv
// Combinational occupancy flags for the PCIe lane FIFO.
// Ports: cnt (registered occupancy), umbral_low / umbral_high (thresholds),
// init (active-low soft clear, forces reset values), full/empty/almost flags.
module pcie_fifo_flags
  import pcie_fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic [ADDR_WIDTH:0] cnt,
  input  logic [ADDR_WIDTH:0] umbral_low,
  input  logic [ADDR_WIDTH:0] umbral_high,
  input  logic                init,
  output logic                full_c,
  output logic                empty_c,
  output logic                afull_c,
  output logic                aempty_c
);

  localparam int unsigned CW         = fifo_cnt_width(ADDR_WIDTH);
  localparam int unsigned FIFO_DEPTH = fifo_depth(ADDR_WIDTH);

  logic [CW-1:0] afull_thr;

  // Thresholds at or beyond DEPTH saturate to zero so every non-full count qualifies
  always_comb begin
    afull_thr = '0;
    if (umbral_high < CW'(FIFO_DEPTH)) begin
      afull_thr = CW'(FIFO_DEPTH) - umbral_high;
    end
    full_c   = init & (cnt == CW'(FIFO_DEPTH));
    empty_c  = ~init | (cnt == '0);
    afull_c  = init & (umbral_high != '0) & (cnt >= afull_thr) & (cnt < CW'(FIFO_DEPTH));
    aempty_c = init & (umbral_low != '0) & (cnt != '0) & (cnt <= umbral_low);
  end

endmodule

// File: rtl/pcie_param_fifo.sv
// Parametrised synchronous FIFO between byte striping and a lane serialiser.
// Ports: clk, reset_L (async active-low), init (sync active-low clear),
// wr_enable/data_in (push), rd_enable (pop), data_out/valid_out (read data),
// umbral_low/umbral_high (thresholds), full/empty/almost flags,
// sticky overflow_err/underflow_err, fifo_cnt (occupancy).
// Build option: define PCIE_FIFO_FWFT_EN for first-word-fall-through reads.
module pcie_param_fifo
  import pcie_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  init,
  input  logic                  wr_enable,
  input  logic                  rd_enable,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH:0]   umbral_low,
  input  logic [ADDR_WIDTH:0]   umbral_high,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  full_fifo,
  output logic                  empty_fifo,
  output logic                  almost_full_fifo,
  output logic                  almost_empty_fifo,
  output logic                  overflow_err,
  output logic                  underflow_err,
  output logic [ADDR_WIDTH:0]   fifo_cnt
);

  localparam int unsigned CW         = fifo_cnt_width(ADDR_WIDTH);
  localparam int unsigned FIFO_DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  rd_acc_c, wr_acc_c;

  pcie_fifo_flags #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_flags (
    .cnt         (cnt_q),
    .umbral_low  (umbral_low),
    .umbral_high (umbral_high),
    .init        (init),
    .full_c      (full_fifo),
    .empty_c     (empty_fifo),
    .afull_c     (almost_full_fifo),
    .aempty_c    (almost_empty_fifo)
  );

  // A write at full only goes through when a read frees a slot in the same cycle
  assign rd_acc_c = init & rd_enable & ~empty_fifo;
  assign wr_acc_c = init & wr_enable & (~full_fifo | rd_acc_c);

  // Storage is intentionally left uninitialised
  always_ff @(posedge clk) begin
    if (wr_acc_c) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

`ifdef PCIE_FIFO_FWFT_EN
  // Head word is presented directly; rd_enable acknowledges it
  assign data_out  = empty_fifo ? '0 : mem_q[rd_ptr_q];
  assign valid_out = ~empty_fifo;
`else
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  valid_q, valid_d;

  always_comb begin
    dout_d  = '0;
    valid_d = 1'b0;
    if (rd_acc_c) begin
      dout_d  = mem_q[rd_ptr_q];
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      valid_q <= valid_d;
    end
  end

  assign data_out  = dout_q;
  assign valid_out = valid_q;
`endif

  // Pointer, occupancy and sticky error update; init clears everything
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (!init) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (wr_acc_c) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      if (rd_acc_c) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
      cnt_d = cnt_q + CW'(wr_acc_c) - CW'(rd_acc_c);
      if (wr_enable & full_fifo & ~rd_acc_c) ovf_d = 1'b1;
      // A read paired with a write into an empty FIFO is not an underflow
      if (rd_enable & empty_fifo & ~wr_enable) udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  assign overflow_err  = ovf_q;
  assign underflow_err = udf_q;
  assign fifo_cnt      = cnt_q;

endmodule

// File: tb/tb_pcie_param_fifo.sv
// Directed bench for pcie_param_fifo (DATA_WIDTH=6, ADDR_WIDTH=2).
module tb_pcie_param_fifo;

  typedef struct packed {
    logic [5:0] dout;
    logic       vld, full, empty, af, ae, ovf, udf;
    logic [2:0] cnt;
  } out_t;

  typedef struct {
    string      name;
    logic       init, wr, rd;
    logic [5:0] din;
    logic [2:0] ul, uh;
    out_t       exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_L, init, wr_enable, rd_enable;
  logic [5:0] data_in, data_out;
  logic [2:0] umbral_low, umbral_high, fifo_cnt;
  logic       valid_out, full_fifo, empty_fifo, almost_full_fifo, almost_empty_fifo;
  logic       overflow_err, underflow_err;
  out_t       act;

  int n_checks = 0;
  int n_fail   = 0;

  pcie_param_fifo #(.DATA_WIDTH(6), .ADDR_WIDTH(2)) dut (
    .clk(clk), .reset_L(reset_L), .init(init),
    .wr_enable(wr_enable), .rd_enable(rd_enable), .data_in(data_in),
    .umbral_low(umbral_low), .umbral_high(umbral_high),
    .data_out(data_out), .valid_out(valid_out),
    .full_fifo(full_fifo), .empty_fifo(empty_fifo),
    .almost_full_fifo(almost_full_fifo), .almost_empty_fifo(almost_empty_fifo),
    .overflow_err(overflow_err), .underflow_err(underflow_err),
    .fifo_cnt(fifo_cnt)
  );

  always #5 clk = ~clk;

  assign act = {data_out, valid_out, full_fifo, empty_fifo, almost_full_fifo,
                almost_empty_fifo, overflow_err, underflow_err, fifo_cnt};

  function automatic out_t o(input logic [5:0] d, input logic v, f, e, af, ae, ov, ud,
                             input logic [2:0] c);
    o = {d, v, f, e, af, ae, ov, ud, c};
  endfunction

  function automatic vec_t mk(input string n, input logic i, w, r, input logic [5:0] d,
                              input logic [2:0] ul, uh, input out_t e);
    vec_t v;
    v.name = n; v.init = i; v.wr = w; v.rd = r; v.din = d;
    v.ul = ul; v.uh = uh; v.exp = e;
    return v;
  endfunction

  task automatic chk(input string nm, input out_t a, input out_t e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: actual dout=%h vld=%b full=%b empty=%b af=%b ae=%b ovf=%b udf=%b cnt=%0d | required dout=%h vld=%b full=%b empty=%b af=%b ae=%b ovf=%b udf=%b cnt=%0d",
               nm, a.dout, a.vld, a.full, a.empty, a.af, a.ae, a.ovf, a.udf, a.cnt,
               e.dout, e.vld, e.full, e.empty, e.af, e.ae, e.ovf, e.udf, e.cnt);
    end
  endtask

  task automatic chk_v(input string nm, input int a, input int e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", nm, a, e);
    end
  endtask

  // Drive one cycle of requests and sample #1 after the rising edge
  task automatic step(input logic i, w, r, input logic [5:0] d);
    init = i; wr_enable = w; rd_enable = r; data_in = d;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];

  initial begin
    reset_L = 1'b0; init = 1'b1; wr_enable = 1'b0; rd_enable = 1'b0;
    data_in = '0; umbral_low = 3'd1; umbral_high = 3'd1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", act, o(6'h00, 0, 0, 1, 0, 0, 0, 0, 3'd0));
    @(negedge clk);
    reset_L = 1'b1;
    @(posedge clk);
    #1;

    // Reset asserted mid-stream, between clock edges
    step(1, 1, 0, 6'h11);
    step(1, 1, 0, 6'h22);
    chk_v("two_writes_cnt", int'(fifo_cnt), 2);
    step(1, 0, 1, 6'h00);
    #3 reset_L = 1'b0;
    #1 chk("async_reset", act, o(6'h00, 0, 0, 1, 0, 0, 0, 0, 3'd0));
    reset_L = 1'b1;
    step(1, 0, 1, 6'h00);
    chk("udf_after_reset", act, o(6'h00, 0, 0, 1, 0, 0, 0, 1, 3'd0));

`ifndef PCIE_FIFO_FWFT_EN
    //                 name           init wr rd din    ul    uh     dout  v f e af ae ov ud cnt
    vecs.push_back(mk("init_clr",     0, 0, 0, 6'h00, 3'd1, 3'd1, o(6'h00, 0, 0, 1, 0, 0, 0, 0, 3'd0)));
    vecs.push_back(mk("wr_01",        1, 1, 0, 6'h01, 3'd1, 3'd1, o(6'h00, 0, 0, 0, 0, 1, 0, 0, 3'd1)));
    vecs.push_back(mk("wr_02",        1, 1, 0, 6'h02, 3'd1, 3'd1, o(6'h00, 0, 0, 0, 0, 0, 0, 0, 3'd2)));
    vecs.push_back(mk("wr_03_afull",  1, 1, 0, 6'h03, 3'd1, 3'd1, o(6'h00, 0, 0, 0, 1, 0, 0, 0, 3'd3)));
    vecs.push_back(mk("wr_04_full",   1, 1, 0, 6'h04, 3'd1, 3'd1, o(6'h00, 0, 1, 0, 0, 0, 0, 0, 3'd4)));
    vecs.push_back(mk("full_wr_rd",   1, 1, 1, 6'h3F, 3'd1, 3'd1, o(6'h01, 1, 1, 0, 0, 0, 0, 0, 3'd4)));
    vecs.push_back(mk("overflow",     1, 1, 0, 6'h2A, 3'd1, 3'd1, o(6'h00, 0, 1, 0, 0, 0, 1, 0, 3'd4)));
    vecs.push_back(mk("rd_02",        1, 0, 1, 6'h00, 3'd1, 3'd1, o(6'h02, 1, 0, 0, 1, 0, 1, 0, 3'd3)));
    vecs.push_back(mk("rd_03",        1, 0, 1, 6'h00, 3'd1, 3'd1, o(6'h03, 1, 0, 0, 0, 0, 1, 0, 3'd2)));
    vecs.push_back(mk("rd_04_aempty", 1, 0, 1, 6'h00, 3'd1, 3'd1, o(6'h04, 1, 0, 0, 0, 1, 1, 0, 3'd1)));
    vecs.push_back(mk("rd_3f",        1, 0, 1, 6'h00, 3'd1, 3'd1, o(6'h3F, 1, 0, 1, 0, 0, 1, 0, 3'd0)));
    vecs.push_back(mk("underflow",    1, 0, 1, 6'h00, 3'd1, 3'd1, o(6'h00, 0, 0, 1, 0, 0, 1, 1, 3'd0)));
    vecs.push_back(mk("init_pulse",   0, 0, 0, 6'h00, 3'd1, 3'd1, o(6'h00, 0, 0, 1, 0, 0, 0, 0, 3'd0)));
    vecs.push_back(mk("empty_wr_rd",  1, 1, 1, 6'h15, 3'd1, 3'd1, o(6'h00, 0, 0, 0, 0, 1, 0, 0, 3'd1)));
    vecs.push_back(mk("rd_15",        1, 0, 1, 6'h00, 3'd1, 3'd1, o(6'h15, 1, 0, 1, 0, 0, 0, 0, 3'd0)));
    vecs.push_back(mk("thr2_wr_05",   1, 1, 0, 6'h05, 3'd2, 3'd2, o(6'h00, 0, 0, 0, 0, 1, 0, 0, 3'd1)));
    vecs.push_back(mk("thr2_wr_06",   1, 1, 0, 6'h06, 3'd2, 3'd2, o(6'h00, 0, 0, 0, 1, 1, 0, 0, 3'd2)));
    vecs.push_back(mk("thr0_off",     1, 0, 0, 6'h00, 3'd0, 3'd0, o(6'h00, 0, 0, 0, 0, 0, 0, 0, 3'd2)));
    vecs.push_back(mk("uh7_saturate", 1, 0, 0, 6'h00, 3'd3, 3'd7, o(6'h00, 0, 0, 0, 1, 1, 0, 0, 3'd2)));
    vecs.push_back(mk("uh4_depth",    1, 0, 0, 6'h00, 3'd1, 3'd4, o(6'h00, 0, 0, 0, 1, 0, 0, 0, 3'd2)));
    vecs.push_back(mk("mid_wr_rd",    1, 1, 1, 6'h07, 3'd1, 3'd1, o(6'h05, 1, 0, 0, 0, 0, 0, 0, 3'd2)));
    vecs.push_back(mk("rd_06",        1, 0, 1, 6'h00, 3'd1, 3'd1, o(6'h06, 1, 0, 0, 0, 1, 0, 0, 3'd1)));
    vecs.push_back(mk("rd_07",        1, 0, 1, 6'h00, 3'd1, 3'd1, o(6'h07, 1, 0, 1, 0, 0, 0, 0, 3'd0)));

    for (int i = 0; i < vecs.size(); i++) begin
      umbral_low  = vecs[i].ul;
      umbral_high = vecs[i].uh;
      step(vecs[i].init, vecs[i].wr, vecs[i].rd, vecs[i].din);
      chk(vecs[i].name, act, vecs[i].exp);
    end
`else
    umbral_low = 3'd1; umbral_high = 3'd1;
    step(0, 0, 0, 6'h00);
    chk("fwft_init_clr", act, o(6'h00, 0, 0, 1, 0, 0, 0, 0, 3'd0));
`endif

    // Wrap-around: two words of slack, then ten simultaneous push/pop cycles
    umbral_low = 3'd1; umbral_high = 3'd1;
    step(1, 1, 0, 6'h20);
`ifdef PCIE_FIFO_FWFT_EN
    chk_v("fwft_head_after_write", int'({valid_out, data_out}), int'({1'b1, 6'h20}));
`endif
    step(1, 1, 0, 6'h21);
    for (int i = 0; i < 10; i++) begin
`ifdef PCIE_FIFO_FWFT_EN
      chk_v($sformatf("fwft_wrap_%0d", i), int'({valid_out, data_out, fifo_cnt}),
            int'({1'b1, 6'(8'h20 + i), 3'd2}));
      step(1, 1, 1, 6'(8'h22 + i));
`else
      step(1, 1, 1, 6'(8'h22 + i));
      chk_v($sformatf("wrap_%0d", i), int'({valid_out, data_out, fifo_cnt}),
            int'({1'b1, 6'(8'h20 + i), 3'd2}));
`endif
    end
`ifdef PCIE_FIFO_FWFT_EN
    chk_v("fwft_drain_2a", int'({valid_out, data_out}), int'({1'b1, 6'h2A}));
    step(1, 0, 1, 6'h00);
    chk_v("fwft_drain_2b", int'({valid_out, data_out}), int'({1'b1, 6'h2B}));
    step(1, 0, 1, 6'h00);
    chk_v("fwft_drained", int'({valid_out, data_out, empty_fifo}), int'({1'b0, 6'h00, 1'b1}));
`else
    step(1, 0, 1, 6'h00);
    chk_v("drain_2a", int'({valid_out, data_out}), int'({1'b1, 6'h2A}));
    step(1, 0, 1, 6'h00);
    chk_v("drain_2b", int'({valid_out, data_out, empty_fifo}), int'({1'b1, 6'h2B, 1'b1}));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
